// File: rtl/latency_stats_collector.sv
// Running statistics (count, sum, min, max, timeouts) over timer interval results,
// plus a small sample FIFO for slow-control readout. Single clock domain.
module latency_stats_collector #(
   parameter int                DATA_W      = 8,
   parameter int                CNT_W       = 16,
   parameter int                SUM_W       = 24,
   parameter int                FIFO_DEPTH  = 16,
   parameter logic [DATA_W-1:0] TIMEOUT_VAL = {DATA_W{1'b1}}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            meas_in,
   input  logic                         meas_valid,
   input  logic                         clear,
   input  logic                         rd_en,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic                         fifo_empty,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         overflow,
   output logic [CNT_W-1:0]             sample_cnt,
   output logic [CNT_W-1:0]             timeout_cnt,
   output logic [SUM_W-1:0]             sum,
   output logic [DATA_W-1:0]            min_val,
   output logic [DATA_W-1:0]            max_val
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_level;
   logic              r_empty;
   logic              r_full;
   logic              r_overflow;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic [CNT_W-1:0]  r_sample_cnt;
   logic [CNT_W-1:0]  r_timeout_cnt;
   logic [SUM_W-1:0]  r_sum;
   logic [DATA_W-1:0] r_min;
   logic [DATA_W-1:0] r_max;

   logic              w_clr;
   logic              w_is_timeout;
   logic              w_accept;
   logic              w_pop;
   logic              w_push;
   logic [AW:0]       w_level_nxt;
   logic [SUM_W:0]    w_sum_ext;
   logic [SUM_W-1:0]  w_sum_sat;

   // Sample classification, FIFO handshake and saturating sum
   always_comb begin
      w_clr        = reset || clear;
      w_is_timeout = meas_valid && (meas_in == TIMEOUT_VAL);
      w_accept     = meas_valid && !w_is_timeout;
      w_pop        = rd_en && !r_empty;
      // a full FIFO still takes the sample when a pop frees the slot this cycle
      w_push       = w_accept && (!r_full || w_pop);
      w_sum_ext    = {1'b0, r_sum} + {{(SUM_W+1-DATA_W){1'b0}}, meas_in};
      if (w_sum_ext[SUM_W]) begin
         w_sum_sat = {SUM_W{1'b1}};
      end else begin
         w_sum_sat = w_sum_ext[SUM_W-1:0];
      end
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + (AW+1)'(1);
         2'b01:   w_level_nxt = r_level - (AW+1)'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // Statistics accumulators
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_sample_cnt  <= {CNT_W{1'b0}};
         r_timeout_cnt <= {CNT_W{1'b0}};
         r_sum         <= {SUM_W{1'b0}};
         r_min         <= {DATA_W{1'b1}};
         r_max         <= {DATA_W{1'b0}};
      end else begin
         if (w_is_timeout && (r_timeout_cnt != {CNT_W{1'b1}})) begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            if (r_sample_cnt != {CNT_W{1'b1}}) begin
               r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
            r_sum <= w_sum_sat;
            if (meas_in < r_min) begin
               r_min <= meas_in;
            end
            if (meas_in > r_max) begin
               r_max <= meas_in;
            end
         end
      end
   end

   // FIFO storage, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (w_push && !w_clr) begin
         r_mem[r_wr_ptr] <= meas_in;
      end
   end

   // FIFO pointers, occupancy flags, read port and overflow flag
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wr_ptr   <= {AW{1'b0}};
         r_rd_ptr   <= {AW{1'b0}};
         r_level    <= {(AW+1){1'b0}};
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_data  <= {DATA_W{1'b0}};
         r_rd_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_rd_data <= r_mem[r_rd_ptr];
         end
         if (w_accept && !w_push) begin
            r_overflow <= 1'b1;
         end
         r_rd_valid <= w_pop;
         r_level    <= w_level_nxt;
         r_empty    <= (w_level_nxt == {(AW+1){1'b0}});
         r_full     <= (w_level_nxt == DEPTH_L);
      end
   end

   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign fifo_empty  = r_empty;
   assign fifo_full   = r_full;
   assign fifo_level  = r_level;
   assign overflow    = r_overflow;
   assign sample_cnt  = r_sample_cnt;
   assign timeout_cnt = r_timeout_cnt;
   assign sum         = r_sum;
   assign min_val     = r_min;
   assign max_val     = r_max;

endmodule

// File: tb/tb_latency_stats_collector.sv
// Self-checking bench: behavioural model with a queue-based FIFO and a readout scoreboard.
module tb_latency_stats_collector;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic [7:0] meas_in;
   logic       meas_valid;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       fifo_empty;
   logic       fifo_full;
   logic [4:0] fifo_level;
   logic       overflow;
   logic [15:0] sample_cnt;
   logic [15:0] timeout_cnt;
   logic [23:0] sum;
   logic [7:0] min_val;
   logic [7:0] max_val;

   logic [7:0] d2_meas_in;
   logic       d2_meas_valid;
   logic       d2_rd_en;
   logic [7:0] d2_rd_data;
   logic       d2_rd_valid;
   logic       d2_fifo_empty;
   logic       d2_fifo_full;
   logic [4:0] d2_fifo_level;
   logic       d2_overflow;
   logic [15:0] d2_sample_cnt;
   logic [15:0] d2_timeout_cnt;
   logic [9:0] d2_sum;
   logic [7:0] d2_min_val;
   logic [7:0] d2_max_val;

   always #5 clk = ~clk;

   latency_stats_collector dut (
      .clk(clk), .reset(reset), .meas_in(meas_in), .meas_valid(meas_valid),
      .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
      .overflow(overflow), .sample_cnt(sample_cnt), .timeout_cnt(timeout_cnt),
      .sum(sum), .min_val(min_val), .max_val(max_val)
   );

   latency_stats_collector #(.SUM_W(10)) dut2 (
      .clk(clk), .reset(reset), .meas_in(d2_meas_in), .meas_valid(d2_meas_valid),
      .clear(clear), .rd_en(d2_rd_en), .rd_data(d2_rd_data), .rd_valid(d2_rd_valid),
      .fifo_empty(d2_fifo_empty), .fifo_full(d2_fifo_full), .fifo_level(d2_fifo_level),
      .overflow(d2_overflow), .sample_cnt(d2_sample_cnt), .timeout_cnt(d2_timeout_cnt),
      .sum(d2_sum), .min_val(d2_min_val), .max_val(d2_max_val)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int m_cnt, m_to, m_sum, m_min, m_max, m_rd_data;
   bit m_ovf;
   bit exp_rv;
   int q_model[$];
   int exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_to = 0; m_sum = 0; m_min = 255; m_max = 0; m_rd_data = 0;
      m_ovf = 1'b0; exp_rv = 1'b0;
      q_model.delete();
      exp_q.delete();
   endtask

   task automatic check_stats(input string tag);
      check_eq({tag, ".sample_cnt"}, sample_cnt, m_cnt);
      check_eq({tag, ".timeout_cnt"}, timeout_cnt, m_to);
      check_eq({tag, ".sum"}, sum, m_sum);
      check_eq({tag, ".min_val"}, min_val, m_min);
      check_eq({tag, ".max_val"}, max_val, m_max);
      check_eq({tag, ".fifo_level"}, fifo_level, q_model.size());
      check_eq({tag, ".fifo_empty"}, fifo_empty, q_model.size() == 0);
      check_eq({tag, ".fifo_full"}, fifo_full, q_model.size() == DEPTH);
      check_eq({tag, ".overflow"}, overflow, m_ovf);
      check_eq({tag, ".rd_data"}, rd_data, m_rd_data);
   endtask

   // One clock cycle on the main DUT: drive, update model, compare readout after the edge
   task automatic step(input bit v, input int m, input bit rd, input bit clr);
      bit pop;
      meas_valid = v; meas_in = 8'(m); rd_en = rd; clear = clr;
      if (clr) begin
         model_reset();
      end else begin
         pop = rd && (q_model.size() > 0);
         exp_rv = pop;
         if (pop) begin
            m_rd_data = q_model.pop_front();
            exp_q.push_back(m_rd_data);
         end
         if (v) begin
            if (m == 255) begin
               if (m_to < 65535) m_to++;
            end else begin
               if (m_cnt < 65535) m_cnt++;
               m_sum = (m_sum + m > 24'hFFFFFF) ? 24'hFFFFFF : m_sum + m;
               if (m < m_min) m_min = m;
               if (m > m_max) m_max = m;
               if (q_model.size() < DEPTH) q_model.push_back(m);
               else m_ovf = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      meas_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
      check_eq("rd_valid", rd_valid, exp_rv);
      if (rd_valid) begin
         if (exp_q.size() > 0) check_eq("rd_data_sb", rd_data, exp_q.pop_front());
         else check_eq("rd_spurious", rd_valid, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; meas_in = 8'd0; meas_valid = 1'b0; rd_en = 1'b0;
      d2_meas_in = 8'd0; d2_meas_valid = 1'b0; d2_rd_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_stats("reset");
      check_eq("reset.min_ff", min_val, 8'hFF);
      check_eq("reset.rd_valid", rd_valid, 1'b0);

      // 5, 9, 3 back to back then three reads
      step(1, 5, 0, 0); step(1, 9, 0, 0); step(1, 3, 0, 0);
      check_eq("tp1.cnt", sample_cnt, 3);
      check_eq("tp1.sum", sum, 17);
      check_eq("tp1.min", min_val, 3);
      check_eq("tp1.max", max_val, 9);
      check_eq("tp1.level", fifo_level, 3);
      step(0, 0, 1, 0); check_eq("tp1.rd0", rd_data, 5);
      step(0, 0, 1, 0); check_eq("tp1.rd1", rd_data, 9);
      step(0, 0, 1, 0); check_eq("tp1.rd2", rd_data, 3);
      check_eq("tp1.empty", fifo_empty, 1'b1);
      step(0, 0, 1, 0);
      check_eq("empty_rd.valid", rd_valid, 1'b0);
      check_eq("empty_rd.hold", rd_data, 3);
      check_stats("tp1");

      // timeout code then a normal sample
      step(0, 0, 0, 1);
      step(1, 255, 0, 0); step(1, 7, 0, 0);
      check_eq("tp2.to", timeout_cnt, 1);
      check_eq("tp2.cnt", sample_cnt, 1);
      check_eq("tp2.min", min_val, 7);
      check_eq("tp2.max", max_val, 7);
      check_eq("tp2.level", fifo_level, 1);
      check_stats("tp2");

      // full FIFO with simultaneous push of 20 and pop
      step(0, 0, 0, 1);
      for (int i = 1; i <= 16; i++) step(1, i, 0, 0);
      check_eq("tp4.full", fifo_full, 1'b1);
      step(1, 20, 1, 0);
      check_eq("tp4.level", fifo_level, 16);
      check_eq("tp4.ovf", overflow, 1'b0);
      check_eq("tp4.rd", rd_data, 1);
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
      check_eq("tp4.last", rd_data, 20);
      check_stats("tp4");

      // 17 samples without reads -> overflow
      step(0, 0, 0, 1);
      for (int i = 1; i <= 17; i++) step(1, i, 0, 0);
      check_eq("tp3.full", fifo_full, 1'b1);
      check_eq("tp3.ovf", overflow, 1'b1);
      check_eq("tp3.cnt", sample_cnt, 17);
      check_eq("tp3.sum", sum, 153);
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 1, 0);
         check_eq("tp3.rd", rd_data, i);
      end
      check_stats("tp3");

      // clear coincident with a sample and a read
      step(1, 4, 0, 0); step(1, 6, 0, 0);
      step(1, 4, 1, 1);
      check_eq("tp5.cnt", sample_cnt, 0);
      check_eq("tp5.empty", fifo_empty, 1'b1);
      check_eq("tp5.min", min_val, 8'hFF);
      check_eq("tp5.ovf", overflow, 1'b0);
      check_stats("tp5");

      // random mixed traffic, occasional clear
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 254),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 99) == 0);
         check_stats("rand");
      end
      check_eq("sb.drained", exp_q.size(), 0);

      // narrow sum accumulator instance
      step(0, 0, 0, 1);
      d2_rd_en = 1'b1;
      @(posedge clk); #1;
      d2_rd_en = 1'b0;
      check_eq("d2.empty_rd", d2_rd_valid, 1'b0);
      d2_meas_valid = 1'b1; d2_meas_in = 8'd254;
      repeat (5) @(posedge clk);
      #1 d2_meas_valid = 1'b0;
      check_eq("d2.sum", d2_sum, 1023);
      check_eq("d2.cnt", d2_sample_cnt, 5);
      check_eq("d2.max", d2_max_val, 254);
      check_eq("d2.rd_valid", d2_rd_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/latency_stats_collector.md
Name: latency_stats_collector

Overview:
- Downstream consumer of the clock-cycle timer that measures the interval between two link event strobes.
- Takes each 8-bit interval result with a valid strobe and maintains running statistics: count, sum, min, max and timeout count.
- Buffers individual samples in a small FIFO for readout by the slow-control / IPbus side.
- Everything runs in the single Aurora user clock domain.

Parameters:
- DATA_W, 8, width of one interval measurement.
- CNT_W, 16, width of the sample and timeout counters.
- SUM_W, 24, width of the sum accumulator.
- FIFO_DEPTH, 16, sample FIFO depth in entries; must be a power of 2, minimum 2.
- TIMEOUT_VAL, all-ones of DATA_W, measurement code meaning "no stop event / timer saturated".

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- meas_in  in  DATA_W  interval result from the timer.
- meas_valid  in  1  one-cycle strobe; meas_in is valid this cycle.
- clear  in  1  synchronous stats/FIFO clear; same effect as reset.
- rd_en  in  1  FIFO pop request.
- rd_data  out  DATA_W  popped sample.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a valid sample was dropped because the FIFO was full.
- sample_cnt  out  CNT_W  accepted non-timeout samples.
- timeout_cnt  out  CNT_W  samples equal to TIMEOUT_VAL.
- sum  out  SUM_W  sum of accepted samples.
- min_val  out  DATA_W  smallest accepted sample.
- max_val  out  DATA_W  largest accepted sample.

Behaviour:
- Reset / clear values:
  - min_val = all ones; max_val = 0; sum, sample_cnt, timeout_cnt = 0.
  - FIFO empty, fifo_level = 0.
  - rd_data = 0; rd_valid = 0; overflow = 0.
- Priority:
  - reset and clear are equivalent and override everything in the same cycle.
  - A meas_valid or rd_en coincident with clear is discarded; no pop occurs and rd_valid stays 0.
- Sample classification, on a meas_valid cycle:
  - meas_in == TIMEOUT_VAL: timeout_cnt += 1, saturating at all ones. No other state changes; the sample is not pushed.
  - Otherwise the sample is accepted, and every statistics output reflects it on the next clk edge (1-cycle latency):
    - sample_cnt += 1, saturating.
    - sum += meas_in, zero-extended, saturating at 2^SUM_W-1.
    - min_val = min(min_val, meas_in).
    - max_val = max(max_val, meas_in).
- Statistics rules:
  - Statistics continue updating after sample_cnt saturates.
  - Back-to-back meas_valid on every cycle is supported with no loss in the statistics path.
- FIFO push:
  - An accepted sample is pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set; overflow clears only on reset/clear.
  - A dropped sample is still counted in all statistics.
- FIFO pop:
  - rd_en with fifo_empty = 0 pops the oldest entry.
  - rd_data is registered and rd_valid = 1 on the following cycle only.
  - rd_en while empty is ignored: rd_valid = 0 and rd_data holds its last value.
  - A push into an empty FIFO is not poppable in the same cycle; first read is the next cycle at the earliest.
- Occupancy:
  - Simultaneous push and pop leaves fifo_level unchanged.
  - fifo_empty, fifo_full and fifo_level are registered and consistent with each other every cycle.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Storage is inferred register/distributed RAM; no vendor primitives.

Test Plan:
- Reset, then meas 5, 9, 3 on consecutive cycles -> sample_cnt=3, sum=17, min_val=3, max_val=9, fifo_level=3; three rd_en pulses return 5, 9, 3 with rd_valid each following cycle, then fifo_empty=1.
- meas 0xFF, then meas 7 -> timeout_cnt=1, sample_cnt=1, min_val=max_val=7, fifo_level=1.
- 17 accepted samples 1..17, no reads (FIFO_DEPTH=16) -> fifo_full=1, overflow=1, sample_cnt=17, sum=153; 16 reads return 1..16.
- FIFO full, meas_valid with value 20 plus rd_en same cycle -> fifo_level stays 16, overflow stays 0, rd_data=oldest entry, and the last entry read out is 20.
- clear asserted with meas_valid=1 and meas_in=4 in the same cycle after prior samples -> all outputs return to reset values; sample_cnt=0, fifo_empty=1.
- SUM_W=10 override, five samples of 254 -> sum=1023 (saturated), sample_cnt=5, max_val=254; rd_en on empty FIFO -> rd_valid stays 0.
